vga_line_fetch: RTL and testbench

Line-prefetch stage that sits directly upstream of the VGA controller and supplies its 24-bit pixel input. Using the controller's registered row/column/read-strobe outputs, it fetches the next display line from framebuffer memory into a ping-pong line buffer while the current line is being displayed. It serves pixels from that buffer with zero read latency.

---
 rtl/vga_line_fetch.sv | 117 +++++++++++
 tb/tb_vga_line_fetch.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// Line-prefetch stage for the VGA controller. While one line is on screen it fetches
// the next one from the framebuffer into a ping-pong buffer; pixels are read with no latency.
module vga_line_fetch #(
    parameter int H_PIX   = 640,
    parameter int V_LINES = 480
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    output logic [23:0] pix_data,
    output logic        mem_req,
    output logic [18:0] mem_addr,
    input  logic        mem_ack,
    input  logic [23:0] mem_rdata,
    output logic        busy,
    output logic        underrun
);

    typedef enum logic [1:0] {INIT, IDLE, FETCH} state_t;

    localparam logic [9:0]  LAST_COL = 10'(H_PIX - 1);
    localparam logic [8:0]  LAST_ROW = 9'(V_LINES - 1);
    localparam logic [10:0] COL_LIM  = 11'(H_PIX);
    localparam logic [9:0]  ROW_LIM  = 10'(V_LINES);

    state_t      state, state_n;
    logic [8:0]  tgt, tgt_n, tgt_calc;
    logic [9:0]  cnt, cnt_n;
    logic        underrun_q, underrun_n;
    logic        rdn_q;
    logic        trig;
    logic        wr_en;
    logic        last_ack;

    logic [23:0] buf0 [H_PIX];
    logic [23:0] buf1 [H_PIX];

    assign trig     = rdn_q & ~rdn;
    assign tgt_calc = (row_addr == LAST_ROW) ? '0 : row_addr + 9'd1;
    assign mem_req  = (state == FETCH);
    assign busy     = (state == FETCH);
    assign mem_addr = mem_req ? {tgt, cnt} : '0;
    assign underrun = underrun_q;
    assign wr_en    = mem_req & mem_ack;
    assign last_ack = wr_en && (cnt == LAST_COL);

    always_ff @(posedge vga_clk) begin
        if (!clrn) begin
            rdn_q      <= 1'b1;
            state      <= INIT;
            tgt        <= '0;
            cnt        <= '0;
            underrun_q <= 1'b0;
        end else begin
            rdn_q      <= rdn;
            state      <= state_n;
            tgt        <= tgt_n;
            cnt        <= cnt_n;
            underrun_q <= underrun_n;
        end
    end

    always_comb begin
        state_n    = state;
        tgt_n      = tgt;
        cnt_n      = cnt;
        underrun_n = underrun_q;
        case (state)
            INIT: begin
                tgt_n   = '0;
                cnt_n   = '0;
                state_n = FETCH;
            end
            IDLE: begin
                if (trig) begin
                    tgt_n   = tgt_calc;
                    cnt_n   = '0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                // A new line start abandons the fetch; only a late one (not the final ack) is an underrun.
                if (trig) begin
                    tgt_n = tgt_calc;
                    cnt_n = '0;
                    if (!last_ack) underrun_n = 1'b1;
                end else if (wr_en) begin
                    if (last_ack) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 10'd1;
                    end
                end
            end
            default: state_n = INIT;
        endcase
    end

    // Buffer storage is deliberately not reset; a transfer in a reset cycle is dropped.
    always_ff @(posedge vga_clk) begin
        if (clrn && wr_en) begin
            if (tgt[0]) buf1[cnt] <= mem_rdata;
            else        buf0[cnt] <= mem_rdata;
        end
    end

    always_comb begin
        pix_data = '0;
        if (({1'b0, col_addr} < COL_LIM) && ({1'b0, row_addr} < ROW_LIM)) begin
            pix_data = row_addr[0] ? buf1[col_addr] : buf0[col_addr];
        end
    end

endmodule

// File: tb/tb_vga_line_fetch.sv
// Self-checking bench for vga_line_fetch: framebuffer word = {row,col}, VGA line timing
// model, and a per-buffer record of which row should be resident.
module tb_vga_line_fetch;

    localparam int H_PIX   = 640;
    localparam int V_LINES = 480;

    logic        vga_clk = 1'b0;
    logic        clrn;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic [23:0] pix_data;
    logic        mem_req;
    logic [18:0] mem_addr;
    logic        mem_ack;
    logic [23:0] mem_rdata;
    logic        busy;
    logic        underrun;

    int checks   = 0;
    int failures = 0;
    int loaded[2];
    int last_tgt  = 0;
    int last_acks = 0;

    vga_line_fetch #(.H_PIX(H_PIX), .V_LINES(V_LINES)) dut (
        .vga_clk  (vga_clk),
        .clrn     (clrn),
        .row_addr (row_addr),
        .col_addr (col_addr),
        .rdn      (rdn),
        .pix_data (pix_data),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 vga_clk = ~vga_clk;

    // Framebuffer: every word holds its own {row,col} address.
    assign mem_rdata = {5'd0, mem_addr};

    function automatic logic [23:0] pat(input int r, input int c);
        logic [8:0] rr;
        logic [9:0] cc;
        rr = r[8:0];
        cc = c[9:0];
        return {5'd0, rr, cc};
    endfunction

    function automatic logic [18:0] addr_of(input int r, input int c);
        logic [8:0] rr;
        logic [9:0] cc;
        rr = r[8:0];
        cc = c[9:0];
        return {rr, cc};
    endfunction

    task automatic step(input logic cl, input int r, input int c, input logic rd, input logic ack);
        @(posedge vga_clk);
        #1;
        clrn     = cl;
        row_addr = r[8:0];
        col_addr = c[9:0];
        rdn      = rd;
        mem_ack  = ack;
        #1;
    endtask

    // One 800-cycle line: 640 active (rdn low) + 160 blanking. mode 0 = ack with at most
    // 100 random drops per line, mode 1 = ack on odd cycles only (50%).
    task automatic run_line(input int r, input int mode, input bit expect_idle, input bit exp_underrun);
        int   tgt;
        int   drops;
        int   acks;
        bit   chk_pix;
        logic ack;
        tgt     = (r == V_LINES - 1) ? 0 : r + 1;
        drops   = 0;
        acks    = 0;
        chk_pix = (loaded[r % 2] == r);
        for (int c = 0; c < 800; c++) begin
            if (mode == 0) begin
                if (drops < 100 && $urandom_range(0, 9) == 0) begin
                    ack = 1'b0;
                    drops++;
                end else begin
                    ack = 1'b1;
                end
            end else begin
                ack = c[0];
            end
            step(1'b1, r, c, (c < 640) ? 1'b0 : 1'b1, ack);
            if (c >= 1 && ack) acks++;
            if (c == 0) begin
                checks++;
                if (expect_idle) begin
                    if (busy !== 1'b0) begin
                        failures++;
                        $display("FAIL line_start_idle row=%0d: busy=%b expected 0", r, busy);
                    end
                end else begin
                    if (busy !== 1'b1 || mem_addr !== addr_of(last_tgt, last_acks)) begin
                        failures++;
                        $display("FAIL line_start_pending row=%0d: busy=%b addr=%h expected busy=1 addr=%h",
                                 r, busy, mem_addr, addr_of(last_tgt, last_acks));
                    end
                end
            end
            if (c == 1) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== addr_of(tgt, 0)) begin
                    failures++;
                    $display("FAIL trig_fetch row=%0d: req=%b addr=%h expected req=1 addr=%h",
                             r, mem_req, mem_addr, addr_of(tgt, 0));
                end
                checks++;
                if (underrun !== exp_underrun) begin
                    failures++;
                    $display("FAIL underrun_after_trig row=%0d: got %b expected %b", r, underrun, exp_underrun);
                end
            end
            checks++;
            if (c < 640 && chk_pix) begin
                if (pix_data !== pat(r, c)) begin
                    failures++;
                    $display("FAIL pix row=%0d col=%0d: got %h expected %h", r, c, pix_data, pat(r, c));
                end
            end else if (c >= 640) begin
                if (pix_data !== 24'h0) begin
                    failures++;
                    $display("FAIL pix_blank row=%0d col=%0d: got %h expected 0", r, c, pix_data);
                end
            end else begin
                checks--;
            end
            if (c == 799) begin
                checks++;
                if (underrun !== exp_underrun) begin
                    failures++;
                    $display("FAIL underrun_line_end row=%0d: got %b expected %b", r, underrun, exp_underrun);
                end
                if (mode == 0) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        failures++;
                        $display("FAIL fetch_in_budget row=%0d: busy=%b expected 0", r, busy);
                    end
                end
            end
        end
        loaded[tgt % 2] = (mode == 0) ? tgt : -1;
        last_tgt  = tgt;
        last_acks = acks;
    endtask

    task automatic test_reset();
        clrn = 1'b0; rdn = 1'b1; row_addr = '0; col_addr = '0; mem_ack = 1'b0;
        step(1'b0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b1);
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0 || mem_addr !== 19'd0) begin
            failures++;
            $display("FAIL reset_state: req=%b busy=%b underrun=%b addr=%h expected 0/0/0/0",
                     mem_req, busy, underrun, mem_addr);
        end
        step(1'b1, 0, 0, 1'b1, 1'b1);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL release_init: req=%b expected 0", mem_req);
        end
    endtask

    task automatic test_first_fetch();
        for (int j = 0; j < H_PIX; j++) begin
            step(1'b1, 0, 0, 1'b1, 1'b1);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== addr_of(0, j)) begin
                failures++;
                $display("FAIL first_fetch j=%0d: req=%b addr=%h expected req=1 addr=%h",
                         j, mem_req, mem_addr, addr_of(0, j));
            end
        end
        step(1'b1, 0, 0, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL first_fetch_done: busy=%b req=%b expected 0/0", busy, mem_req);
        end
        loaded[0] = 0;
        loaded[1] = -1;
        for (int k = 0; k < 16; k++) begin
            int c;
            c = $urandom_range(0, H_PIX - 1);
            step(1'b1, 0, c, 1'b1, 1'b0);
            checks++;
            if (pix_data !== pat(0, c)) begin
                failures++;
                $display("FAIL buf0_row0 col=%0d: got %h expected %h", c, pix_data, pat(0, c));
            end
        end
    endtask

    task automatic test_frame();
        for (int r = 0; r <= 6; r++) run_line(r, 0, 1'b1, 1'b0);
        run_line(478, 0, 1'b1, 1'b0);
        run_line(479, 0, 1'b1, 1'b0);
        run_line(0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        int old_row;
        old_row = loaded[1];
        step(1'b1, 20, 0, 1'b1, 1'b1);
        step(1'b1, 20, 0, 1'b0, 1'b1);
        for (int j = 0; j < 100; j++) begin
            step(1'b1, 20, 0, 1'b0, 1'b1);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== addr_of(21, j)) begin
                failures++;
                $display("FAIL stall_pre j=%0d: addr=%h expected %h", j, mem_addr, addr_of(21, j));
            end
        end
        for (int j = 0; j < 10; j++) begin
            int c;
            c = (j % 2 == 0) ? 100 : 99;
            step(1'b1, 21, c, 1'b0, 1'b0);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== addr_of(21, 100)) begin
                failures++;
                $display("FAIL stall_hold j=%0d: req=%b addr=%h expected req=1 addr=%h",
                         j, mem_req, mem_addr, addr_of(21, 100));
            end
            checks++;
            if (pix_data !== ((c == 100) ? pat(old_row, 100) : pat(21, 99))) begin
                failures++;
                $display("FAIL stall_nowrite col=%0d: got %h expected %h", c, pix_data,
                         (c == 100) ? pat(old_row, 100) : pat(21, 99));
            end
        end
        for (int j = 100; j < H_PIX; j++) begin
            step(1'b1, 21, 0, 1'b0, 1'b1);
            checks++;
            if (mem_addr !== addr_of(21, j)) begin
                failures++;
                $display("FAIL stall_resume j=%0d: addr=%h expected %h", j, mem_addr, addr_of(21, j));
            end
        end
        step(1'b1, 21, 100, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b0 || pix_data !== pat(21, 100)) begin
            failures++;
            $display("FAIL stall_done: busy=%b pix=%h expected busy=0 pix=%h", busy, pix_data, pat(21, 100));
        end
        loaded[1] = 21;
    endtask

    task automatic test_underrun();
        run_line(30, 1, 1'b1, 1'b0);
        run_line(31, 1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midfetch();
        step(1'b1, 40, 0, 1'b1, 1'b1);
        step(1'b1, 40, 0, 1'b0, 1'b1);
        for (int j = 0; j < 300; j++) begin
            step(1'b1, 40, 0, 1'b0, 1'b1);
            checks++;
            if (mem_addr !== addr_of(41, j)) begin
                failures++;
                $display("FAIL pre_reset j=%0d: addr=%h expected %h", j, mem_addr, addr_of(41, j));
            end
        end
        step(1'b0, 40, 0, 1'b1, 1'b1);
        step(1'b0, 40, 0, 1'b1, 1'b1);
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0 || mem_addr !== 19'd0) begin
            failures++;
            $display("FAIL midfetch_reset: req=%b busy=%b underrun=%b addr=%h expected 0/0/0/0",
                     mem_req, busy, underrun, mem_addr);
        end
        step(1'b1, 40, 0, 1'b1, 1'b1);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL midfetch_release: req=%b expected 0", mem_req);
        end
        for (int j = 0; j < H_PIX; j++) begin
            step(1'b1, 40, 0, 1'b1, 1'b1);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== addr_of(0, j)) begin
                failures++;
                $display("FAIL refetch j=%0d: req=%b addr=%h expected req=1 addr=%h",
                         j, mem_req, mem_addr, addr_of(0, j));
            end
        end
        for (int k = 0; k < 8; k++) begin
            int c;
            c = $urandom_range(0, H_PIX - 1);
            step(1'b1, 0, c, 1'b1, 1'b0);
            checks++;
            if (busy !== 1'b0 || pix_data !== pat(0, c)) begin
                failures++;
                $display("FAIL refetch_row0 col=%0d: busy=%b pix=%h expected busy=0 pix=%h",
                         c, busy, pix_data, pat(0, c));
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 18; k++) begin
            int r;
            int c;
            if (k == 0) begin
                r = 0; c = 700;
            end else if (k == 1) begin
                r = 490; c = 5;
            end else if (k < 10) begin
                r = $urandom_range(0, V_LINES - 1);
                c = $urandom_range(H_PIX, 1023);
            end else begin
                r = $urandom_range(V_LINES, 511);
                c = $urandom_range(0, H_PIX - 1);
            end
            step(1'b1, r, c, 1'b1, 1'b0);
            checks++;
            if (pix_data !== 24'h0) begin
                failures++;
                $display("FAIL out_of_range row=%0d col=%0d: got %h expected 0", r, c, pix_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_frame();
        test_stall();
        test_underrun();
        test_reset_midfetch();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
